// File: rtl/ps2_key_cmd_if.sv
// ps2_key_cmd_if
// Command stream from the key command block to the video pipeline controller.
// Transfer happens on a cycle where cmd_valid and cmd_ready are both high.
//   cmd_valid  producer -> consumer  head entry present
//   cmd_ready  consumer -> producer  head accepted this cycle
//   cmd_code   producer -> consumer  1 SET, 2 NEXT, 3 PREV, 4 BYPASS, 5 HOME, 0 when empty
//   cmd_arg    producer -> consumer  style index after command, or bypass flag for BYPASS
interface ps2_key_cmd_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_code;
    logic [3:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_code,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_code,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/ps2_key_cmd.sv
// ps2_key_cmd
// Turns released PS/2 scan codes into style-transfer commands. A registered decode
// stage is followed by a state-update stage that also writes the command into a
// first-word-fallthrough FIFO read through cmd_if.
//   clk         system clock
//   reset       asynchronous active-high reset
//   key_valid   one-cycle tick, key_code holds a released scan code
//   key_code    scan code
//   cmd_if      command stream (master side)
//   style_idx   current style index, 0..NUM_STYLES-1
//   bypass      current bypass flag
//   fifo_count  entries held in the command FIFO
//   overflow    sticky, a command was dropped on a full FIFO
module ps2_key_cmd #(
    parameter int NUM_STYLES = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key_valid,
    input  logic [7:0]           key_code,
    ps2_key_cmd_if.master        cmd_if,
    output logic [3:0]           style_idx,
    output logic                 bypass,
    output logic [4:0]           fifo_count,
    output logic                 overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_SET    = 3'd1;
    localparam logic [2:0] CMD_NEXT   = 3'd2;
    localparam logic [2:0] CMD_PREV   = 3'd3;
    localparam logic [2:0] CMD_BYPASS = 3'd4;
    localparam logic [2:0] CMD_HOME   = 3'd5;

    localparam logic [3:0] MAX_IDX   = 4'(NUM_STYLES - 1);
    localparam logic [4:0] NUM_STY_W = 5'(NUM_STYLES);
    localparam logic [4:0] DEPTH_W   = 5'(FIFO_DEPTH);

    // decode stage
    logic       dec_valid_d, dec_valid_q;
    logic [2:0] dec_cmd_d,   dec_cmd_q;
    logic [3:0] dec_digit_d, dec_digit_q;
    logic       digit_hit;

    // state stage
    logic [3:0] style_d,  style_q;
    logic       bypass_d, bypass_q;
    logic [3:0] push_arg;
    logic       push;

    // command FIFO, entry = {code, arg}
    logic [6:0]       mem_d [FIFO_DEPTH];
    logic [6:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [4:0]       count_d,  count_q;
    logic             overflow_d, overflow_q;
    logic             empty, full, pop, push_ok;
    logic [6:0]       head;

    //------------------------------------------------------------------
    // Decode
    //------------------------------------------------------------------
    always_comb begin
        dec_valid_d = 1'b0;
        dec_cmd_d   = CMD_NONE;
        dec_digit_d = 4'd0;
        digit_hit   = 1'b0;
        if (key_valid) begin
            case (key_code)
                8'h45: begin digit_hit = 1'b1; dec_digit_d = 4'd0; end
                8'h16: begin digit_hit = 1'b1; dec_digit_d = 4'd1; end
                8'h1E: begin digit_hit = 1'b1; dec_digit_d = 4'd2; end
                8'h26: begin digit_hit = 1'b1; dec_digit_d = 4'd3; end
                8'h25: begin digit_hit = 1'b1; dec_digit_d = 4'd4; end
                8'h2E: begin digit_hit = 1'b1; dec_digit_d = 4'd5; end
                8'h36: begin digit_hit = 1'b1; dec_digit_d = 4'd6; end
                8'h3D: begin digit_hit = 1'b1; dec_digit_d = 4'd7; end
                8'h3E: begin digit_hit = 1'b1; dec_digit_d = 4'd8; end
                8'h46: begin digit_hit = 1'b1; dec_digit_d = 4'd9; end
                8'h31: begin dec_valid_d = 1'b1; dec_cmd_d = CMD_NEXT;   end
                8'h4D: begin dec_valid_d = 1'b1; dec_cmd_d = CMD_PREV;   end
                8'h29: begin dec_valid_d = 1'b1; dec_cmd_d = CMD_BYPASS; end
                8'h2D: begin dec_valid_d = 1'b1; dec_cmd_d = CMD_HOME;   end
                default: ;
            endcase
            // Digits naming a style that does not exist are dropped here, so
            // they never reach the state stage or the FIFO.
            if (digit_hit) begin
                if ({1'b0, dec_digit_d} < NUM_STY_W) begin
                    dec_valid_d = 1'b1;
                    dec_cmd_d   = CMD_SET;
                end else begin
                    dec_digit_d = 4'd0;
                end
            end
        end
    end

    //------------------------------------------------------------------
    // State update and FIFO entry
    //------------------------------------------------------------------
    always_comb begin
        style_d  = style_q;
        bypass_d = bypass_q;
        push     = dec_valid_q;
        if (dec_valid_q) begin
            case (dec_cmd_q)
                CMD_SET:    style_d = dec_digit_q;
                CMD_NEXT:   style_d = (style_q == MAX_IDX) ? 4'd0 : style_q + 4'd1;
                CMD_PREV:   style_d = (style_q == 4'd0) ? MAX_IDX : style_q - 4'd1;
                CMD_BYPASS: bypass_d = ~bypass_q;
                CMD_HOME: begin
                    style_d  = 4'd0;
                    bypass_d = 1'b0;
                end
                default: ;
            endcase
        end
        push_arg = (dec_cmd_q == CMD_BYPASS) ? {3'b000, bypass_d} : style_d;
    end

    //------------------------------------------------------------------
    // FIFO control
    //------------------------------------------------------------------
    always_comb begin
        empty   = (count_q == 5'd0);
        full    = (count_q == DEPTH_W);
        head    = mem_q[rd_ptr_q];
        pop     = !empty && cmd_if.cmd_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok = push && (!full || pop);

        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || (push && !push_ok);

        if (push_ok) begin
            mem_d[wr_ptr_q] = {dec_cmd_q, push_arg};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    //------------------------------------------------------------------
    // Registers
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_valid_q <= 1'b0;
            dec_cmd_q   <= CMD_NONE;
            dec_digit_q <= 4'd0;
            style_q     <= 4'd0;
            bypass_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= 5'd0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 7'd0;
            end
        end else begin
            dec_valid_q <= dec_valid_d;
            dec_cmd_q   <= dec_cmd_d;
            dec_digit_q <= dec_digit_d;
            style_q     <= style_d;
            bypass_q    <= bypass_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            mem_q       <= mem_d;
        end
    end

    //------------------------------------------------------------------
    // Outputs, all from registered state
    //------------------------------------------------------------------
    assign cmd_if.cmd_valid = !empty;
    assign cmd_if.cmd_code  = empty ? 3'd0 : head[6:4];
    assign cmd_if.cmd_arg   = empty ? 4'd0 : head[3:0];
    assign style_idx        = style_q;
    assign bypass           = bypass_q;
    assign fifo_count       = count_q;
    assign overflow         = overflow_q;

endmodule
